pipe_hazard_ctrl: RTL

Pipeline sequencing controller that sits beside the decode stage. It keeps a per-register scoreboard of in-flight writes and generates the stall, flush and bubble controls for IF/ID/EX. It serialises sprite-unit read/write commands against the busy sprite unit. It also drains the pipeline and parks the core after HALT.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 30 +++
 rtl/pipe_hazard_ctrl_if.sv | 54 +++++
 rtl/pipe_hazard_ctrl_scoreboard.sv | 100 ++++++++++
 rtl/pipe_hazard_ctrl.sv | 111 +++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and sizes for the pipeline hazard controller
//               (FSM states, register address type, scoreboard counters).
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  localparam int NREG         = 32;
  localparam int CNT_W        = 2;
  localparam int MAX_INFLIGHT = 3;
  localparam int REG_AW       = $clog2(NREG);

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hz_state_t;

  // r0 is hard-wired, so it never participates in tracking
  function automatic logic reg_tracked(input reg_addr_t a);
    return (a != '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_if
// Description : Decode/EX/WB/sprite-side signals seen by the hazard
//               controller, and the pipeline controls it returns.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if;
  import pipe_ctrl_pkg::*;

  // decode stage
  logic      id_valid;
  reg_addr_t id_regS;
  reg_addr_t id_regT;
  logic      id_reS;
  logic      id_reT;
  reg_addr_t id_dst_reg;
  logic      id_use_dst;
  logic      id_sprite_op;
  logic      id_hlt;
  // execute / writeback / sprite unit
  logic      ex_mispredict;
  logic      wb_we;
  reg_addr_t wb_dst_reg;
  logic      spr_busy;
  // controls back to the pipeline
  logic      stall_if;
  logic      stall_id;
  logic      flush_if_id;
  logic      bubble_ex;
  logic      id_issue;
  logic      halted;
  logic      sb_err;

  // pipeline side
  modport master (
    output id_valid, id_regS, id_regT, id_reS, id_reT, id_dst_reg,
           id_use_dst, id_sprite_op, id_hlt, ex_mispredict, wb_we,
           wb_dst_reg, spr_busy,
    input  stall_if, stall_id, flush_if_id, bubble_ex, id_issue, halted,
           sb_err
  );

  // controller side
  modport slave (
    input  id_valid, id_regS, id_regT, id_reS, id_reT, id_dst_reg,
           id_use_dst, id_sprite_op, id_hlt, ex_mispredict, wb_we,
           wb_dst_reg, spr_busy,
    output stall_if, stall_id, flush_if_id, bubble_ex, id_issue, halted,
           sb_err
  );

endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hz_scoreboard
// Description : Per-register in-flight write counters. Counts up when a
//               writing instruction issues, down on WB, and answers the
//               read-after-write and saturation lookups for ID.
// Revision    : 1.0 - initial release
// ============================================================================
module hz_scoreboard
  import pipe_ctrl_pkg::*;
(
  input  wire logic      clk,
  input  wire logic      rst_n,
  input  wire reg_addr_t rs_addr_i,
  input  wire logic      rs_rd_i,
  input  wire reg_addr_t rt_addr_i,
  input  wire logic      rt_rd_i,
  input  wire reg_addr_t dst_addr_i,
  input  wire logic      dst_use_i,
  input  wire logic      issue_i,
  input  wire logic      wb_we_i,
  input  wire reg_addr_t wb_addr_i,
  output logic           raw_o,
  output logic           sat_o,
  output logic           all_zero_o,
  output logic           sb_err_o
);

  cnt_t cnt_q [NREG];
  cnt_t cnt_d [NREG];
  logic sb_err_q;
  logic sb_err_d;

  logic w_inc;
  logic w_dec;

  assign w_inc = issue_i & dst_use_i & reg_tracked(dst_addr_i);
  assign w_dec = wb_we_i & reg_tracked(wb_addr_i);

  // next counter values; simultaneous inc+dec on one register cancels out
  always_comb begin
    sb_err_d = sb_err_q;
    for (int r = 0; r < NREG; r++) begin
      logic inc_r;
      logic dec_r;
      cnt_d[r] = cnt_q[r];
      inc_r    = w_inc & (dst_addr_i == REG_AW'(r));
      dec_r    = w_dec & (wb_addr_i == REG_AW'(r));
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (inc_r && !dec_r) begin
        cnt_d[r] = cnt_q[r] + cnt_t'(1);
      end else if (dec_r && !inc_r) begin
        if (cnt_q[r] == '0) begin
          // WB for a register nobody is waiting on: flag it, keep count at 0
          sb_err_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] - cnt_t'(1);
        end
      end
    end
  end

  // counter array and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      sb_err_q <= sb_err_d;
    end
  end

  // zero-latency lookups for the instruction sitting in ID
  always_comb begin
    raw_o = (rs_rd_i & reg_tracked(rs_addr_i) & (cnt_q[rs_addr_i] != '0)) |
            (rt_rd_i & reg_tracked(rt_addr_i) & (cnt_q[rt_addr_i] != '0));
    sat_o = dst_use_i & reg_tracked(dst_addr_i) &
            (cnt_q[dst_addr_i] == cnt_t'(MAX_INFLIGHT));
  end

  // pipeline is quiescent when no register has a write outstanding
  always_comb begin
    all_zero_o = 1'b1;
    for (int r = 0; r < NREG; r++) begin
      if (cnt_q[r] != '0) begin
        all_zero_o = 1'b0;
      end
    end
  end

  assign sb_err_o = sb_err_q;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Decode-side sequencing controller: RAW/saturation/sprite
//               stalls, mispredict flush, and HALT drain-and-park FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
(
  input  wire logic          clk,
  input  wire logic          rst_n,
  pipe_hazard_ctrl_if.slave  ctrl
);

  hz_state_t state_q;
  hz_state_t state_d;

  logic w_raw;
  logic w_sat;
  logic w_spr;
  logic w_all_zero;
  logic w_sb_err;
  logic w_hold;
  logic w_stall;
  logic w_flush;
  logic w_bubble;
  logic w_issue;

  hz_scoreboard u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs_addr_i  (ctrl.id_regS),
    .rs_rd_i    (ctrl.id_reS),
    .rt_addr_i  (ctrl.id_regT),
    .rt_rd_i    (ctrl.id_reT),
    .dst_addr_i (ctrl.id_dst_reg),
    .dst_use_i  (ctrl.id_use_dst),
    .issue_i    (w_issue),
    .wb_we_i    (ctrl.wb_we),
    .wb_addr_i  (ctrl.wb_dst_reg),
    .raw_o      (w_raw),
    .sat_o      (w_sat),
    .all_zero_o (w_all_zero),
    .sb_err_o   (w_sb_err)
  );

  assign w_spr  = ctrl.id_sprite_op & ctrl.spr_busy;
  assign w_hold = ctrl.id_valid & (w_raw | w_sat | w_spr | (state_q != RUN));

  // stall/flush priority and FSM next state; mispredict only acts in RUN
  always_comb begin
    w_stall  = 1'b0;
    w_flush  = 1'b0;
    w_bubble = 1'b0;
    w_issue  = 1'b0;
    state_d  = state_q;

    if ((state_q == RUN) && ctrl.ex_mispredict) begin
      w_flush  = 1'b1;
      w_bubble = 1'b1;
    end else begin
      w_stall  = w_hold;
      w_bubble = w_hold;
      w_issue  = ctrl.id_valid & ~w_hold;
    end

    // draining or parked: front end is frozen regardless of ID contents
    if (state_q != RUN) begin
      w_stall = 1'b1;
    end

    case (state_q)
      RUN: begin
        if (w_issue && ctrl.id_hlt) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (w_all_zero && !ctrl.spr_busy) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign ctrl.stall_if    = w_stall;
  assign ctrl.stall_id    = w_stall;
  assign ctrl.flush_if_id = w_flush;
  assign ctrl.bubble_ex   = w_bubble;
  assign ctrl.id_issue    = w_issue;
  assign ctrl.halted      = (state_q == HALTED);
  assign ctrl.sb_err      = w_sb_err;

endmodule
`default_nettype wire
